// File: rtl/wb_stage_if.sv
// MEM->WB handshake, load-response and regfile/forwarding bus of the write-back stage.
// master drives the retiring instruction and load response; slave is the stage itself.
interface wb_stage_if #(
   parameter int unsigned CNT_W = 32
);
   logic             mem_valid;
   logic [4:0]       mem_Rd;
   logic             mem_RegWrite;
   logic [1:0]       mem_Sel2Reg;
   logic [63:0]      mem_ALUResult;
   logic [63:0]      mem_LinkAddr;
   logic             rdata_valid;
   logic [63:0]      rdata;

   logic [4:0]       WriteRegister;
   logic [63:0]      WriteData;
   logic             RegWrite;
   logic [15:0]      MEM_WR_Rd;
   logic [63:0]      MEM_WR_Data;
   logic             MEM_WR_RegWrite;
   logic             stall;
   logic             load_err;
   logic [CNT_W-1:0] retired;

   modport master (
      output mem_valid, mem_Rd, mem_RegWrite, mem_Sel2Reg, mem_ALUResult, mem_LinkAddr,
             rdata_valid, rdata,
      input  WriteRegister, WriteData, RegWrite, MEM_WR_Rd, MEM_WR_Data, MEM_WR_RegWrite,
             stall, load_err, retired
   );

   modport slave (
      input  mem_valid, mem_Rd, mem_RegWrite, mem_Sel2Reg, mem_ALUResult, mem_LinkAddr,
             rdata_valid, rdata,
      output WriteRegister, WriteData, RegWrite, MEM_WR_Rd, MEM_WR_Data, MEM_WR_RegWrite,
             stall, load_err, retired
   );
endinterface

// File: rtl/wb_stage.sv
// LEGv8 write-back stage: one registered commit slot feeding the regfile write port and
// the MEM/WB forwarding bus, stalling upstream while a data-memory load is outstanding.
module wb_stage #(
   parameter int unsigned LOAD_TIMEOUT = 16,
   parameter int unsigned CNT_W        = 32
) (
   input  logic       clk,
   input  logic       reset,
   wb_stage_if.slave  bus
);

   localparam int unsigned CW      = 8;
   localparam logic [CW-1:0] TO_LAST = CW'(LOAD_TIMEOUT - 1);
   localparam logic [4:0]  XZR      = 5'd31;
   localparam logic [1:0]  SEL_LOAD = 2'b01;
   localparam logic [1:0]  SEL_LINK = 2'b10;

   typedef enum logic {IDLE, WAIT_LOAD} state_e;

   state_e           state_q, state_d;
   logic [4:0]       wr_rd_q, wr_rd_d;
   logic [63:0]      wr_data_q, wr_data_d;
   logic             wr_en_q, wr_en_d;
   logic [4:0]       ld_rd_q, ld_rd_d;
   logic             ld_we_q, ld_we_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   // State and commit-slot registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_rd_q   <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         ld_rd_q   <= '0;
         ld_we_q   <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_rd_q   <= wr_rd_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         ld_rd_q   <= ld_rd_d;
         ld_we_q   <= ld_we_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         retired_q <= retired_d;
      end
   end

   // Next-state: a response or the last wait cycle both end the load
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.mem_valid && bus.mem_Sel2Reg == SEL_LOAD) state_d = WAIT_LOAD;
         WAIT_LOAD: if (bus.rdata_valid || cnt_q == TO_LAST)         state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Slot update: address/data only move on a real write, so they hold otherwise
   always_comb begin
      wr_rd_d   = wr_rd_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      ld_rd_d   = ld_rd_q;
      ld_we_d   = ld_we_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      retired_d = retired_q;
      case (state_q)
         IDLE: begin
            if (bus.mem_valid) begin
               if (bus.mem_Sel2Reg == SEL_LOAD) begin
                  ld_rd_d = bus.mem_Rd;
                  ld_we_d = bus.mem_RegWrite;
                  cnt_d   = '0;
               end else begin
                  retired_d = retired_q + CNT_W'(1);
                  if (bus.mem_RegWrite && bus.mem_Rd != XZR) begin
                     wr_en_d   = 1'b1;
                     wr_rd_d   = bus.mem_Rd;
                     wr_data_d = (bus.mem_Sel2Reg == SEL_LINK) ? bus.mem_LinkAddr
                                                               : bus.mem_ALUResult;
                  end
               end
            end
         end
         WAIT_LOAD: begin
            if (bus.rdata_valid) begin
               retired_d = retired_q + CNT_W'(1);
               if (ld_we_q && ld_rd_q != XZR) begin
                  wr_en_d   = 1'b1;
                  wr_rd_d   = ld_rd_q;
                  wr_data_d = bus.rdata;
               end
            end else if (cnt_q == TO_LAST) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.WriteRegister   = wr_rd_q;
   assign bus.WriteData       = wr_data_q;
   assign bus.RegWrite        = wr_en_q;
   assign bus.MEM_WR_Rd       = {11'b0, wr_rd_q};
   assign bus.MEM_WR_Data     = wr_data_q;
   assign bus.MEM_WR_RegWrite = wr_en_q;
   assign bus.stall           = (state_q == WAIT_LOAD);
   assign bus.load_err        = err_q;
   assign bus.retired         = retired_q;

endmodule
